// File: rtl/debounce_edge.sv
// Synchronizes and debounces a raw asynchronous input into a clean level with rise/fall pulses.
// Optional rejected-transition counter port glitch_cnt_o is enabled by defining DEBOUNCE_GLITCH_CNT_EN.
module debounce_edge #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_i,
    output logic       level_o,
    output logic       rise_o,
    output logic       fall_o,
    output logic       busy_o
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt_o
`endif
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Plain shift chain; nothing may sit between stages or metastability settling time is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (sync_s != level_q) begin
                    // A single-cycle qualification window never needs the pending state.
                    if (DEBOUNCE_CYCLES == 1) begin
                        level_d = sync_s;
                        rise_d  = sync_s;
                        fall_d  = ~sync_s;
                    end else begin
                        state_d = ST_PENDING;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_PENDING: begin
                if (sync_s == level_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                    level_d = sync_s;
                    rise_d  = sync_s;
                    fall_d  = ~sync_s;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign busy_o  = (state_q == ST_PENDING);

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic       glitch_ev;
    logic [7:0] glitch_cnt_q;

    assign glitch_ev = (state_q == ST_PENDING) && (sync_s == level_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            glitch_cnt_q <= 8'd0;
        end else if (glitch_ev && (glitch_cnt_q != 8'hFF)) begin
            glitch_cnt_q <= glitch_cnt_q + 8'd1;
        end
    end

    assign glitch_cnt_o = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: per-cycle vector table with an expectation queue, plus
// hand sequences for the single-cycle debounce build and the optional glitch counter.
module tb_debounce_edge;

    logic clk = 1'b0;
    logic reset;
    logic d_i;
    logic level, rise, fall, busy;
    logic level1, rise1, fall1, busy1;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] gcnt, gcnt1;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    debounce_edge #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0)) dut (
        .clk(clk), .reset(reset), .d_i(d_i),
        .level_o(level), .rise_o(rise), .fall_o(fall), .busy_o(busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        , .glitch_cnt_o(gcnt)
`endif
    );

    debounce_edge #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b0)) dut1 (
        .clk(clk), .reset(reset), .d_i(d_i),
        .level_o(level1), .rise_o(rise1), .fall_o(fall1), .busy_o(busy1)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        , .glitch_cnt_o(gcnt1)
`endif
    );

    typedef struct {
        logic rst;
        logic d;
        logic level;
        logic rise;
        logic fall;
        logic busy;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(logic r, logic dd, logic l, logic ri, logic f, logic b);
        vec_t v;
        v.rst = r; v.d = dd; v.level = l; v.rise = ri; v.fall = f; v.busy = b;
        return v;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic glitch();
        d_i = 1'b1; step(); step();
        d_i = 1'b0; step(); step(); step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t e;
        reset = 1'b1;
        d_i   = 1'b1;

        // reset held with d_i high
        repeat (3) tbl.push_back(mk(1, 1, 0, 0, 0, 0));
        // clean rise: busy from E3, level/rise on E6
        tbl.push_back(mk(0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0));
        // clean fall
        tbl.push_back(mk(0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0));
        // two-cycle bounce is rejected
        tbl.push_back(mk(0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0));
        // reset on third pending cycle, then full requalification
        tbl.push_back(mk(0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0));
        // reset drops a high level without a fall pulse
        tbl.push_back(mk(1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst;
            d_i   = tbl[i].d;
            sb.push_back(tbl[i]);
            step();
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL row%0d scoreboard: queue empty, expected one entry", i);
            end else begin
                e = sb.pop_front();
                check($sformatf("row%0d level", i), level, e.level);
                check($sformatf("row%0d rise", i), rise, e.rise);
                check($sformatf("row%0d fall", i), fall, e.fall);
                check($sformatf("row%0d busy", i), busy, e.busy);
            end
        end

        // single-cycle debounce: three-edge latency
        reset = 1'b1; d_i = 1'b0; step();
        reset = 1'b0; d_i = 1'b1;
        step(); check("dc1 E1 level", level1, 1'b0);
        step(); check("dc1 E2 level", level1, 1'b0);
        step(); check("dc1 E3 level", level1, 1'b1);
        check("dc1 E3 rise", rise1, 1'b1);
        check("dc1 E3 busy", busy1, 1'b0);
        step(); check("dc1 E4 rise", rise1, 1'b0);
        check("dc1 E4 level", level1, 1'b1);
        d_i = 1'b0;
        step(); step(); step();
        check("dc1 fall E3 level", level1, 1'b0);
        check("dc1 fall E3 fall", fall1, 1'b1);
        step(); check("dc1 fall E4 fall", fall1, 1'b0);

`ifdef DEBOUNCE_GLITCH_CNT_EN
        reset = 1'b1; d_i = 1'b0; step();
        check8("gcnt after reset", gcnt, 8'd0);
        reset = 1'b0;
        glitch();
        check8("gcnt one glitch", gcnt, 8'd1);
        check("gcnt one glitch level", level, 1'b0);
        d_i = 1'b1; repeat (8) step();
        check("gcnt qualified rise level", level, 1'b1);
        check8("gcnt after qualified rise", gcnt, 8'd1);
        d_i = 1'b0; repeat (8) step();
        check("gcnt qualified fall level", level, 1'b0);
        check8("gcnt after qualified fall", gcnt, 8'd1);
        repeat (253) glitch();
        check8("gcnt 254 glitches", gcnt, 8'd254);
        repeat (47) glitch();
        check8("gcnt saturated", gcnt, 8'd255);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/debounce_edge.md
Name: debounce_edge

Overview:
- Conditions a raw, asynchronous, possibly bouncy single-bit input (button, strap, external flag) before it reaches the plain DFF storage stages.
- Synchronizes the input into clk, debounces it with a consecutive-cycle counter, and produces a clean level.
- Also produces single-cycle rise and fall pulses for downstream registers and control logic.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops (legal range >= 2).
- DEBOUNCE_CYCLES, 16, consecutive sampled cycles the synchronized value must differ from level_o before level_o changes (legal range >= 1).
- RESET_LEVEL, 1'b0, value loaded into the synchronizer chain and level_o on reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- d_i  input  1  raw asynchronous input.
- level_o  output  1  debounced, synchronized level.
- rise_o  output  1  one-cycle pulse when level_o goes 0->1.
- fall_o  output  1  one-cycle pulse when level_o goes 1->0.
- busy_o  output  1  high while a candidate transition is being qualified.
- glitch_cnt_o  output  8  rejected-transition count; present only with DEBOUNCE_GLITCH_CNT_EN.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset. Reset is sampled only on posedge clk and overrides all other activity.
- Reset values:
  - sync chain = RESET_LEVEL; level_o = RESET_LEVEL.
  - rise_o = fall_o = 0; busy_o = 0.
  - counter = 0; state = STABLE; glitch_cnt_o = 0.
  - Reset never generates rise_o or fall_o, including when it changes level_o mid-operation.
- Synchronizer: shift chain of SYNC_STAGES flops; d_i enters stage 0. The last stage is sync_s. No logic between stages.
- Counter width: $clog2(DEBOUNCE_CYCLES+1), unsigned. It never wraps.
- State STABLE (sync_s == level_o):
  - cnt held at 0.
  - If sync_s != level_o and DEBOUNCE_CYCLES == 1: level_o <= sync_s, emit pulse, stay STABLE.
  - Else if sync_s != level_o: go to PENDING, cnt <= 1.
- State PENDING:
  - If sync_s == level_o: glitch; go to STABLE, cnt <= 0, no pulse, glitch count +1.
  - Else if cnt == DEBOUNCE_CYCLES-1: level_o <= sync_s, cnt <= 0, go to STABLE, emit pulse.
  - Else: cnt <= cnt+1.
- Pulse rule:
  - rise_o or fall_o is registered and asserted in the same cycle level_o first shows its new value.
  - The pulse is high for exactly one cycle. rise_o and fall_o are never high together.
- busy_o = (state == PENDING), registered.
- Latency: a clean d_i step is visible on level_o on the (SYNC_STAGES + DEBOUNCE_CYCLES)-th posedge after d_i settles, counting the first capturing edge as 1.
- Minimum pulse spacing: back-to-back opposite transitions need at least DEBOUNCE_CYCLES cycles between level_o changes.
- A bounce that returns before qualification produces no output activity other than busy_o.

Optional Feature:
- Macro: DEBOUNCE_GLITCH_CNT_EN.
- Defined:
  - Port glitch_cnt_o exists.
  - Increments by 1 on every PENDING->STABLE glitch exit.
  - Saturates at 8'hFF.
  - Cleared only by reset.
  - Qualified transitions do not increment it.
- Undefined:
  - Port and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
(SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0 unless noted)
1. Reset 3 cycles, d_i=1 during reset -> level_o=0, rise_o=0, busy_o=0 throughout reset and on the first cycle after release.
2. Clean d_i 0->1 before edge E1 -> busy_o high from E3; level_o=1 and rise_o=1 on E6 only; rise_o=0 on E7; fall_o stays 0.
3. d_i=1 for 2 cycles then back to 0 -> busy_o pulses, level_o stays 0, no rise_o; with DEBOUNCE_GLITCH_CNT_EN, glitch_cnt_o=1.
4. 300 glitches with DEBOUNCE_GLITCH_CNT_EN -> glitch_cnt_o saturates at 255.
5. level_o=1 steady, d_i 1->0 held -> fall_o single pulse, level_o=0 after 6 edges.
6. Reset asserted on cycle 3 of PENDING -> next cycle busy_o=0, cnt=0, no pulse; d_i still 1 after release -> full 6-edge qualification restarts, then rise_o. Also with DEBOUNCE_CYCLES=1, a step gives a 3-edge latency.
